// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic ADDR_TXDATA = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    // Assemble the STATUS word; unused upper bits read as zero.
    function automatic logic [15:0] status_word(input logic full,
                                                input logic empty,
                                                input logic busy,
                                                input logic ovf);
        logic [15:0] w;
        w           = '0;
        w[ST_FULL]  = full;
        w[ST_EMPTY] = empty;
        w[ST_BUSY]  = busy;
        w[ST_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through output. A push while
// full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Next-state for pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; no reset needed since occupancy gates its use.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a byte FIFO, a baud
// counter and FSM serialise bytes onto UART_TX, STATUS reports FIFO/FSM state.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        UART_TX
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          baud_done;
    logic          unused_wr_hi;

    // Upper data bits carry no meaning for either register.
    assign unused_wr_hi = ^wr_data[15:8];

    assign fifo_push = wr_en && (addr == ADDR_TXDATA);
    assign baud_done = (baud_q == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wr_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame sequencing: baud counting, bit index, shift register and pops.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Back-to-back: next start bit follows immediately.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Serial line level derived from the state being entered so it is registered.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Sticky overflow: a dropped push sets it, a STATUS write with bit3 clears it.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && (addr == ADDR_STATUS) && wr_data[ST_OVF]) begin
            ovf_d = 1'b0;
        end
        if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    // FSM, counters, shift register, line output and overflow registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign UART_TX = tx_q;
    assign rd_data = status_word(fifo_full, fifo_empty, (state_q != IDLE), ovf_q);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4 and a 4-entry FIFO.
// Line level and STATUS are logged every cycle; frames are checked afterwards.
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int LOG_N = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        addr = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic [15:0] rd_data;
    logic        UART_TX;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic        tx_log [LOG_N];
    logic [15:0] st_log [LOG_N];

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .UART_TX (UART_TX)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle k's outputs are recorded mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            tx_log[cyc] = UART_TX;
            st_log[cyc] = rd_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input logic a, input logic [15:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        addr    = 1'b0;
        wr_data = 16'h0000;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare 10 bit-times of logged line level against an 8N1 frame of b.
    task automatic chk_frame(input string tag, input int s, input logic [7:0] b);
        logic [63:0] o;
        logic [63:0] e;
        o = '0;
        e = '0;
        for (int i = 0; i < 10 * CPB; i++) begin
            o[i] = tx_log[s + i];
            if (i < CPB)           e[i] = 1'b0;
            else if (i < 9 * CPB)  e[i] = b[(i / CPB) - 1];
            else                   e[i] = 1'b1;
        end
        chk(tag, o, e);
    endtask

    initial begin
        int n;
        int m;
        int p;
        logic [63:0] v;

        // Reset state
        tick(); tick(); tick();
        chk("reset_tx", {63'd0, UART_TX}, 64'd1);
        chk("reset_status", {48'd0, rd_data}, 64'h0002);
        reset = 1'b1;
        tick();
        chk("post_reset_status", {48'd0, rd_data}, 64'h0002);

        // Single frame 0x55 and latency
        n = cyc;
        wr(1'b0, 16'h0055);
        chk("n1_status", {48'd0, rd_data}, 64'h0000);
        chk("n1_tx", {63'd0, UART_TX}, 64'd1);
        tick();
        chk("n2_status", {48'd0, rd_data}, 64'h0006);
        chk("n2_tx", {63'd0, UART_TX}, 64'd0);
        wait_until(n + 42);
        chk_frame("frame_55", n + 2, 8'h55);
        v = '0;
        for (int i = 0; i < 10 * CPB; i++) v[i] = st_log[n + 2 + i][2];
        chk("busy_window_55", v, {24'd0, {40{1'b1}}});
        chk("n42_status", {48'd0, rd_data}, 64'h0002);
        chk("n42_tx", {63'd0, UART_TX}, 64'd1);

        // Upper data bits ignored
        n = cyc;
        wr(1'b0, 16'hAB3C);
        wait_until(n + 43);
        chk_frame("frame_3c", n + 2, 8'h3C);
        chk("after_3c_status", {48'd0, rd_data}, 64'h0002);

        // Six writes: fill, overflow, clear, back-to-back frames
        n = cyc;
        for (int k = 1; k <= 6; k++) wr(1'b0, 16'(k));
        chk("ovf_status", {48'd0, rd_data}, 64'h000D);
        wr(1'b1, 16'h0007);
        chk("status_wr_no_bit3", {48'd0, rd_data}, 64'h000D);
        wr(1'b1, 16'h0008);
        chk("ovf_cleared", {48'd0, rd_data}, 64'h0005);
        wr_en = 1'b0; addr = 1'b0; wr_data = 16'h0099;
        tick();
        wr_data = 16'h0000;
        chk("wr_en_low_no_effect", {48'd0, rd_data}, 64'h0005);
        wait_until(n + 203);
        for (int j = 0; j < 5; j++) begin
            chk_frame($sformatf("b2b_frame_%0d", j + 1), n + 2 + 40 * j, 8'(j + 1));
        end
        chk("b2b_idle_tx", {63'd0, tx_log[n + 202]}, 64'd1);
        chk("b2b_idle_status", {48'd0, st_log[n + 202]}, 64'h0002);

        // Reset during DATA discards frame and FIFO contents
        p = cyc;
        wr(1'b0, 16'h00FF);
        wr(1'b0, 16'h0000);
        wait_until(p + 10);
        chk("pre_reset_busy", {63'd0, rd_data[2]}, 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_reset_tx", {63'd0, UART_TX}, 64'd1);
        chk("mid_reset_status", {48'd0, rd_data}, 64'h0002);
        wait_until(p + 80);
        v = '0;
        for (int i = 0; i < 64; i++) v[i] = tx_log[p + 11 + i];
        chk("no_frame_after_reset", v, {64{1'b1}});

        // Push on last STOP cycle while full: accepted with simultaneous pop
        m = cyc;
        for (int k = 1; k <= 5; k++) wr(1'b0, 16'(16'h0010 + k));
        wait_until(m + 41);
        chk("full_before_swap", {48'd0, rd_data}, 64'h0005);
        wr(1'b0, 16'h0016);
        chk("full_after_swap", {48'd0, rd_data}, 64'h0005);
        wait_until(m + 243);
        for (int j = 0; j < 6; j++) begin
            chk_frame($sformatf("swap_frame_%0d", j + 1), m + 2 + 40 * j, 8'(8'h11 + j));
        end
        chk("swap_end_status", {48'd0, st_log[m + 242]}, 64'h0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
